// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtraction controller.
//   state_e   : controller FSM states (IDLE, RUN, DONE)
//   cnt_width : width of the bit counter for a given operand width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter only has to reach w-1, so clog2(w) bits suffice.
  // The floor of 1 keeps the vector legal for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Handshake and data bundle of serial_sub_ctrl.
//   master : operand producer / result consumer (testbench or parent)
//   slave  : the controller
// Signals: start_valid/start_ready + x, y, borrow_in (operand channel);
//          done_valid/done_ready + result, borrow_out (result channel);
//          busy status; zero/ovf flags only when SERIAL_SUB_FLAGS_EN is defined.
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high; the producer holds its payload
// stable while valid is high and ready is low.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 5
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             borrow_in;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] result;
  logic             borrow_out;
  logic             busy;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic             ovf;
`endif

  modport master (
    output start_valid, x, y, borrow_in, done_ready,
    input  start_ready, done_valid, result, borrow_out, busy
`ifdef SERIAL_SUB_FLAGS_EN
    , input zero, ovf
`endif
  );

  modport slave (
    input  start_valid, x, y, borrow_in, done_ready,
    output start_ready, done_valid, result, borrow_out, busy
`ifdef SERIAL_SUB_FLAGS_EN
    , output zero, ovf
`endif
  );
endinterface

// File: rtl/serial_sub_ctrl_fs_bit.sv
// fs_bit: one-bit combinational full subtractor, computes a - b - bin.
//   a_i, b_i, bin_i : minuend bit, subtrahend bit, incoming borrow
//   d_o             : difference bit
//   bout_o          : outgoing borrow
module fs_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial x - y - borrow_in, one bit per clock through
// a single fs_bit cell.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset
//   bus     : serial_sub_ctrl_if slave modport (operands, result, status)
//   state_o : current FSM state, for observation
// Build option: SERIAL_SUB_FLAGS_EN adds the registered zero/ovf flags.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_sub_ctrl_if.slave   bus,
  output state_e             state_o
);
  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
  logic             b_q, b_d, bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero_q, zero_d, ovf_q, ovf_d;
`endif

  logic d_bit, b_next, last_bit;

  fs_bit u_fs_bit (
    .a_i    (x_q[0]),
    .b_i    (y_q[0]),
    .bin_i  (b_q),
    .d_o    (d_bit),
    .bout_o (b_next)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    b_d     = b_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_SUB_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          x_d     = bus.x;
          y_d     = bus.y;
          b_d     = bus.borrow_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d   = x_q >> 1;
        y_d   = y_q >> 1;
        // LSB-first: after WIDTH shifts the first difference bit is at bit 0.
        res_d = {d_bit, res_q[WIDTH-1:1]};
        b_d   = b_next;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
          bout_d  = b_next;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_d  = ({d_bit, res_q[WIDTH-1:1]} == '0);
          // Signed overflow: borrow into the sign cell differs from borrow out.
          ovf_d   = b_q ^ b_next;
`endif
        end
      end
      DONE: begin
        if (bus.done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      b_q     <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      b_q     <= b_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_FLAGS_EN
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Moore outputs decoded from the state register only.
  assign bus.start_ready = (state_q == IDLE);
  assign bus.done_valid  = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.result      = res_q;
  assign bus.borrow_out  = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign bus.zero        = zero_q;
  assign bus.ovf         = ovf_q;
`endif
  assign state_o         = state_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=5): directed cases,
// backpressure with a pending start, reset mid-RUN, then random traffic.
// Honours SERIAL_SUB_FLAGS_EN for the zero/ovf checks.
module tb_serial_sub_ctrl;
  import serial_sub_pkg::*;

  localparam int WIDTH = 5;
  localparam int EW    = WIDTH + 3;  // {ovf, zero, borrow_out, result}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  logic [EW-1:0] exp_q[$];
  state_e      state_o;

  serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] xv,
                                          input logic [WIDTH-1:0] yv,
                                          input logic bv);
    int ux, uy, sx, sy, diff, sdiff;
    logic [WIDTH-1:0] r;
    logic bo, z, ov;
    ux    = int'(xv);
    uy    = int'(yv);
    diff  = ux - uy - int'(bv);
    r     = WIDTH'(diff);
    bo    = (diff < 0);
    z     = (r == '0);
    sx    = ux - (xv[WIDTH-1] ? (1 << WIDTH) : 0);
    sy    = uy - (yv[WIDTH-1] ? (1 << WIDTH) : 0);
    sdiff = sx - sy - int'(bv);
    ov    = (sdiff < -(1 << (WIDTH - 1))) || (sdiff > (1 << (WIDTH - 1)) - 1);
    return {ov, z, bo, r};
  endfunction

  task automatic check_result(input string tag, input logic [EW-1:0] e);
    check({tag, "_result"}, 32'(bus.result), 32'(e[WIDTH-1:0]));
    check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(e[WIDTH]));
`ifdef SERIAL_SUB_FLAGS_EN
    check({tag, "_zero"}, 32'(bus.zero), 32'(e[WIDTH+1]));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(e[WIDTH+2]));
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv, input logic bv);
    int n = 0;
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.x = xv;
    bus.y = yv;
    bus.borrow_in = bv;
    while (!bus.start_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.start_ready) begin
      check("accept_timeout", 32'(0), 32'(1));
      bus.start_valid = 1'b0;
      return;
    end
    @(negedge clk);  // the rising edge in between accepted the operands
    accept_cyc = cyc;
    bus.start_valid = 1'b0;
    exp_q.push_back(model(xv, yv, bv));
  endtask

  // Wait for the result, hold done_ready low for 'hold' cycles, then take it.
  // With 'chain', a new start is held pending throughout and must be
  // accepted on the edge right after the done handshake.
  task automatic collect(input int hold, input bit chain,
                         input logic [WIDTH-1:0] nx, input logic [WIDTH-1:0] ny,
                         input logic nb);
    int n = 0;
    logic [EW-1:0] e;
    while (!bus.done_valid && n < 4 * WIDTH) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done_valid || exp_q.size() == 0) begin
      check("done_timeout", 32'(0), 32'(1));
      bus.start_valid = 1'b0;
      exp_q.delete();
      return;
    end
    check("latency", 32'(cyc - accept_cyc), 32'(WIDTH));
    e = exp_q.pop_front();
    check_result("done", e);
    if (chain) begin
      bus.start_valid = 1'b1;
      bus.x = nx;
      bus.y = ny;
      bus.borrow_in = nb;
    end
    for (int i = 0; i < hold; i++) begin
      bus.done_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", 32'(bus.done_valid), 32'(1));
      check("hold_start_ready", 32'(bus.start_ready), 32'(0));
      check_result("hold", e);
    end
    bus.done_ready = 1'b1;
    @(negedge clk);
    bus.done_ready = 1'b0;
    check("post_valid", 32'(bus.done_valid), 32'(0));
    check("post_start_ready", 32'(bus.start_ready), 32'(1));
    check_result("post", e);
    if (chain) begin
      @(negedge clk);
      check("chain_busy", 32'(bus.busy), 32'(1));
      check("chain_start_ready", 32'(bus.start_ready), 32'(0));
      accept_cyc = cyc;
      bus.start_valid = 1'b0;
      exp_q.push_back(model(nx, ny, nb));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] rx, ry, nx, ny;
    logic rb, nb;
    bit chain, seen;

    bus.start_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.borrow_in = 1'b0;
    bus.done_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_start_ready", 32'(bus.start_ready), 32'(1));
    check("rst_done_valid", 32'(bus.done_valid), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_result", 32'(bus.result), 32'(0));
    check("rst_borrow", 32'(bus.borrow_out), 32'(0));
    check("rst_state", 32'(state_o), 32'(IDLE));
    rst_n = 1'b1;

    // Directed cases
    send(5'b00000, 5'b00001, 1'b0);
    collect(0, 1'b0, '0, '0, 1'b0);
    send(5'b00110, 5'b00010, 1'b1);
    collect(1, 1'b0, '0, '0, 1'b0);
    send(5'b11111, 5'b11111, 1'b0);
    collect(0, 1'b0, '0, '0, 1'b0);
    // Backpressure with a pending start held through DONE
    send(5'b10100, 5'b01010, 1'b0);
    collect(3, 1'b1, 5'b00111, 5'b01001, 1'b1);
    collect(0, 1'b0, '0, '0, 1'b0);

    // Reset during the third RUN cycle
    send(5'b11111, 5'b00000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'(state_o), 32'(IDLE));
    check("midrst_result", 32'(bus.result), 32'(0));
    check("midrst_done_valid", 32'(bus.done_valid), 32'(0));
    check("midrst_start_ready", 32'(bus.start_ready), 32'(1));
    check("midrst_busy", 32'(bus.busy), 32'(0));
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    seen = 1'b0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      @(negedge clk);
      if (bus.done_valid) seen = 1'b1;
    end
    check("no_done_after_reset", 32'(seen), 32'(0));

    // Random traffic, random backpressure, random back-to-back pending starts
    rx = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    ry = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    rb = 1'($urandom_range(0, 1));
    send(rx, ry, rb);
    for (int t = 0; t < 30; t++) begin
      chain = (t < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
      nx = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      ny = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      nb = 1'($urandom_range(0, 1));
      collect($urandom_range(0, 3), chain, nx, ny, nb);
      if (!chain && t < 29) send(nx, ny, nb);
    end

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller: accepts a WIDTH-bit operand pair through a valid/ready handshake and computes `x - y - borrow_in` one bit per clock through a single full-subtractor cell. The borrow register and the operand/result shift registers carry state between bits. It is the sequenced, area-minimal counterpart to the combinational ripple subtractor in the ALU datapath. Multi-word subtraction chains by feeding `borrow_out` back into `borrow_in` of the next transaction.

## Interface
- WIDTH, default 5: operand and result width in bits; must be 2 or more.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- start_valid  in  1  operand pair presented
- start_ready  out  1  controller can accept operands
- x  in  WIDTH  minuend, sampled on start handshake
- y  in  WIDTH  subtrahend, sampled on start handshake
- borrow_in  in  1  incoming borrow, sampled on start handshake
- done_valid  out  1  result available
- done_ready  in  1  consumer takes result
- result  out  WIDTH  `(x - y - borrow_in) mod 2^WIDTH`
- borrow_out  out  1  1 iff unsigned `x < y + borrow_in`
- busy  out  1  high in RUN and DONE
- zero  out  1  result == 0 (only with SERIAL_SUB_FLAGS_EN)
- ovf  out  1  two's-complement overflow (only with SERIAL_SUB_FLAGS_EN)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid && start_ready: load x and y into shift registers, load the borrow register from borrow_in, clear the bit counter, and go to RUN.
- RUN, once per cycle:
  - Take the LSBs xb and yb and the borrow b.
  - Compute `d = xb ^ yb ^ b` and `b_next = (~xb & yb) | (~(xb ^ yb) & b)`.
  - Shift the operands right and shift d into the result MSB.
  - Update the borrow register to b_next and increment the counter.
  - When the counter equals WIDTH-1, go to DONE.
- DONE:
  - done_valid = 1. result and borrow_out are stable.
  - On done_ready, go to IDLE.
- start_ready = 0 in RUN and DONE. Operands presented then are ignored and remain pending on the handshake.
- result, borrow_out and the flags hold their values after leaving DONE until the next accepted start.
- Reset (synchronous, rst_n low at a rising edge) has priority over everything, in any state:
  - state goes to IDLE;
  - result, borrow_out, counter, shift registers, zero and ovf go to 0;
  - done_valid and busy go to 0 and start_ready goes to 1.
- Reset mid-RUN abandons the operation; no done_valid pulse follows.

## Timing
- Start accepted at edge E0; RUN occupies edges E1..E(WIDTH); done_valid rises after edge E(WIDTH).
- Latency from acceptance to done_valid is WIDTH cycles.
- Minimum period between accepted starts is WIDTH+2 cycles: WIDTH RUN edges, the DONE handshake edge, and the IDLE accept edge. There is no back-to-back acceptance in DONE.
- done_valid stays high for as long as done_ready is low; no timeout.
- start_ready and done_valid are Moore outputs with no combinational path from inputs.
- The counter width is clog2(WIDTH). The counter never wraps, because the FSM leaves RUN at WIDTH-1.

## Configuration
- SERIAL_SUB_FLAGS_EN defined:
  - zero and ovf ports exist.
  - ovf = borrow into the MSB cell XOR borrow out of the MSB cell. It is captured on the last RUN edge.
  - zero is registered with result.
  - Both flags are valid while done_valid = 1.
- SERIAL_SUB_FLAGS_EN undefined: the ports and their registers are absent, and the rest of the behaviour is identical.

## Structure
- The shared package serial_sub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a count-width helper function, clog2-based.
- Sub-module fs_bit is the one-bit combinational full-subtractor cell. It is instantiated once and is the only arithmetic in the block.

## Test plan
All scenarios use WIDTH=5.
- x=00000, y=00001, bin=0: result=11111, borrow_out=1, done_valid 5 cycles after accept.
- x=00110, y=00010, bin=1: result=00011, borrow_out=0.
- x=11111, y=11111, bin=0: result=00000, borrow_out=0, zero=1, ovf=0 (flags build).
- x=10100, y=01010, bin=0: result=01010, borrow_out=0, ovf=1 (-12 - 10), zero=0.
- Backpressure:
  - drive done_ready=0 for 3 cycles with start_valid held high;
  - result stays stable and start_ready stays 0;
  - the new start is accepted exactly 1 cycle after the done handshake.
- Reset mid-operation:
  - rst_n low on RUN cycle 3;
  - next cycle state is IDLE, result=00000, done_valid=0, start_ready=1;
  - no done_valid appears afterwards.
